// File: rtl/rle_encoder.sv
// Run-length encoder: turns a byte stream into (value, length) records, splitting runs at 255.
// Optional idle flush of the pending run is enabled with `define RLE_IDLE_FLUSH_EN.
module rle_encoder #(
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [7:0] run_value,
    output logic [7:0] run_length,
    output logic       run_valid
);

    if (IDLE_CYCLES < 2 || IDLE_CYCLES > 255) begin : g_bad_idle
        $error("rle_encoder: IDLE_CYCLES must be in 2..255");
    end

    logic [7:0] cur_value;
    logic [7:0] cur_len;
    logic       active;

    logic [7:0] nxt_value;
    logic [7:0] nxt_len;
    logic       nxt_active;
    logic       emit;

`ifdef RLE_IDLE_FLUSH_EN
    // idle_cnt counts completed idle cycles, so the flush fires on the
    // IDLE_CYCLES-th consecutive idle cycle and the counter never wraps.
    localparam logic [7:0] FLUSH_AT = 8'(IDLE_CYCLES - 1);

    logic [7:0] idle_cnt;
    logic [7:0] nxt_idle;
    logic       flush;

    assign flush = !data_valid && active && (idle_cnt == FLUSH_AT);

    always_comb begin
        nxt_idle = idle_cnt;
        if (data_valid || flush) begin
            nxt_idle = 8'd0;
        end else if (active) begin
            nxt_idle = idle_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= 8'd0;
        end else begin
            idle_cnt <= nxt_idle;
        end
    end
`else
    logic flush;
    assign flush = 1'b0;
`endif

    always_comb begin
        nxt_value  = cur_value;
        nxt_len    = cur_len;
        nxt_active = active;
        emit       = 1'b0;
        if (data_valid) begin
            if (!active) begin
                nxt_value  = data_in;
                nxt_len    = 8'd1;
                nxt_active = 1'b1;
            end else if (data_in == cur_value && cur_len != 8'd255) begin
                nxt_len = cur_len + 8'd1;
            end else begin
                emit      = 1'b1;
                nxt_value = data_in;
                nxt_len   = 8'd1;
            end
        end else if (flush) begin
            emit       = 1'b1;
            nxt_active = 1'b0;
            nxt_len    = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_value  <= 8'd0;
            cur_len    <= 8'd0;
            active     <= 1'b0;
            run_value  <= 8'd0;
            run_length <= 8'd0;
            run_valid  <= 1'b0;
        end else begin
            cur_value <= nxt_value;
            cur_len   <= nxt_len;
            active    <= nxt_active;
            run_valid <= emit;
            // Record outputs hold between strobes.
            if (emit) begin
                run_value  <= cur_value;
                run_length <= cur_len;
            end
        end
    end

endmodule

// File: tb/tb_rle_encoder.sv
// Bench for rle_encoder: directed sequences plus randomized runs/gaps/resets,
// checked cycle-by-cycle against a stream-level run-length reference model.
module tb_rle_encoder;

    localparam int unsigned IDLE_CYCLES = 4;
    localparam int W = 48;  // {due_step[31:0], value[7:0], length[7:0]}

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic [7:0] run_value;
    logic [7:0] run_length;
    logic       run_valid;

    rle_encoder #(.IDLE_CYCLES(IDLE_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .run_value  (run_value),
        .run_length (run_length),
        .run_valid  (run_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           step_idx = 0;
    logic [7:0]   last_val = 8'd0;
    logic [7:0]   last_len = 8'd0;

    // reference model: pending run in the input stream
    bit         m_active = 1'b0;
    logic [7:0] m_val = 8'd0;
    int         m_len = 0;
    int         m_idle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0d expected %0d", tag, step_idx, got, exp);
        end
    endtask

    task automatic push_record(input logic [7:0] v, input int len);
        exp_q.push_back({step_idx[31:0], v, len[7:0]});
    endtask

    // A byte closes the pending run if it differs or the run is full;
    // with idle flush, IDLE_CYCLES silent cycles also close it.
    task automatic model(input bit v, input logic [7:0] d);
        if (v) begin
            m_idle = 0;
            if (m_active && (d != m_val || m_len == 255)) begin
                push_record(m_val, m_len);
                m_active = 1'b0;
            end
            if (!m_active) begin
                m_active = 1'b1;
                m_val    = d;
                m_len    = 1;
            end else begin
                m_len = m_len + 1;
            end
        end else if (m_active) begin
            m_idle = m_idle + 1;
`ifdef RLE_IDLE_FLUSH_EN
            if (m_idle == IDLE_CYCLES) begin
                push_record(m_val, m_len);
                m_active = 1'b0;
                m_idle   = 0;
            end
`endif
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        bit due;
        due = (exp_q.size() > 0) && (exp_q[0][47:16] == step_idx[31:0]);
        check("run_valid", {31'd0, run_valid}, {31'd0, due});
        if (due) begin
            e = exp_q.pop_front();
            check("run_value", {24'd0, run_value}, {24'd0, e[15:8]});
            check("run_length", {24'd0, run_length}, {24'd0, e[7:0]});
            last_val = e[15:8];
            last_len = e[7:0];
        end else begin
            check("hold_value", {24'd0, run_value}, {24'd0, last_val});
            check("hold_length", {24'd0, run_length}, {24'd0, last_len});
        end
        step_idx++;
    endtask

    // driver: one clock cycle with the given input
    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clk);
        monitor();
        data_valid = v;
        data_in    = v ? d : 8'($urandom_range(0, 255));
        model(v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        monitor();
        data_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, run_valid}, 32'd0);
        check("rst_value", {24'd0, run_value}, 32'd0);
        check("rst_length", {24'd0, run_length}, 32'd0);
        exp_q.delete();
        m_active = 1'b0;
        m_len    = 0;
        m_idle   = 0;
        last_val = 8'd0;
        last_len = 8'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_seq(input bit gapped);
        logic [7:0] seq [6];
        seq = '{8'd65, 8'd65, 8'd65, 8'd66, 8'd66, 8'd65};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i]);
            if (gapped) step(1'b0, 8'd0);
        end
        idle(10);
    endtask

    initial begin
        rst        = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_valid", {31'd0, run_valid}, 32'd0);
        check("reset_value", {24'd0, run_value}, 32'd0);
        check("reset_length", {24'd0, run_length}, 32'd0);
        rst = 1'b1;

        // A A A B B A, gapped then back-to-back
        send_seq(1'b1);
        do_reset();
        send_seq(1'b0);
        do_reset();

        // 256 x 0x07 then 0x09: split at 255
        for (int i = 0; i < 256; i++) step(1'b1, 8'h07);
        step(1'b1, 8'h09);
        idle(8);
        do_reset();

        // reset mid-run discards the 0x11 run
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11);
        do_reset();
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        idle(8);
        do_reset();

        // long idle with a pending run, then a terminating byte
        for (int i = 0; i < 3; i++) step(1'b1, 8'h44);
        idle(100);
        step(1'b1, 8'h55);
        idle(8);
        do_reset();

        // idle just short of the flush threshold keeps the run open
        step(1'b1, 8'h66);
        idle(IDLE_CYCLES - 1);
        step(1'b1, 8'h66);
        idle(10);
        do_reset();

        // randomized runs, gaps and occasional resets
        for (int r = 0; r < 500; r++) begin
            int len;
            logic [7:0] v;
            v   = 8'($urandom_range(0, 2));
            len = ($urandom_range(0, 60) == 0) ? int'($urandom_range(250, 300))
                                               : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                int gap;
                step(1'b1, v);
                gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 6))
                                                  : int'($urandom_range(0, 1));
                idle(gap);
            end
            if ($urandom_range(0, 80) == 0) do_reset();
        end
        idle(12);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The module SHALL have parameter IDLE_CYCLES, default 4, giving the idle-cycle count before a pending run is flushed (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port data_in, input, 8 bits: the input byte, sampled only when data_valid=1.
REQ-005 The module SHALL have port data_valid, input, 1 bit: data_in is valid this cycle; there is no backpressure, so every valid byte is accepted.
REQ-006 The module SHALL have port run_value, output, 8 bits: the byte value of the emitted run.
REQ-007 The module SHALL have port run_length, output, 8 bits: the length of the emitted run, 1..255.
REQ-008 The module SHALL have port run_valid, output, 1 bit: a one-cycle strobe qualifying run_value/run_length.

Function
REQ-009 The module SHALL hold internal state: cur_value[7:0], cur_len[7:0], an active flag (run pending), and idle_cnt[7:0].
REQ-010 When data_valid=1 and active=0, the module SHALL set cur_value=data_in, cur_len=1, active=1, and emit nothing.
REQ-011 When data_valid=1, active=1, data_in==cur_value and cur_len<255, the module SHALL increment cur_len and emit nothing.
REQ-012 When data_valid=1, active=1 and either data_in!=cur_value or cur_len==255, the module SHALL register run_value=cur_value, run_length=cur_len, run_valid=1, then restart with cur_value=data_in, cur_len=1.
REQ-013 Latency: run_valid SHALL be high in the cycle immediately following the rising edge that sampled the terminating byte, for exactly one cycle per emitted run.
REQ-014 run_length SHALL never be 0 when run_valid=1; runs longer than 255 SHALL be split into a 255 record followed by the remainder.
REQ-015 run_value and run_length SHALL hold their last emitted values while run_valid=0.
REQ-016 Input bytes SHALL be accepted back-to-back on every cycle and also with arbitrary gaps; gaps SHALL not break a run unless the idle flush fires (REQ-018).
REQ-017 Each emitted record SHALL match the input order exactly; no run is dropped, merged or duplicated.
REQ-018 When data_valid=1, idle_cnt SHALL reset to 0; when data_valid=0 and active=1, idle_cnt SHALL increment (behaviour gated by REQ-023/024).
REQ-019 A flush and a new byte SHALL never coincide: a flush only occurs in a cycle with data_valid=0.

Reset
REQ-020 While rst=0, the module SHALL asynchronously force run_valid=0, run_value=0, run_length=0, cur_value=0, cur_len=0, active=0 and idle_cnt=0.
REQ-021 Reset asserted mid-run SHALL discard the pending run with no emission.
REQ-022 The first data_valid byte sampled on or after the first rising edge with rst=1 SHALL start a new run.

Configuration
REQ-023 With macro RLE_IDLE_FLUSH_EN defined, the module SHALL, when idle_cnt reaches IDLE_CYCLES with active=1, emit the pending run (run_valid=1 next cycle, with values per REQ-012) and set active=0, cur_len=0, idle_cnt=0.
REQ-024 With RLE_IDLE_FLUSH_EN undefined, the module SHALL have no idle counter and no timeout, and a pending run SHALL be held indefinitely until a terminating byte arrives.

Verification
REQ-025 The bench SHALL apply A A A B B A (65,65,65,66,66,65), one byte every other cycle, then idle; the required emissions are (65,3) after the 4th byte and (66,2) after the 6th byte, and with RLE_IDLE_FLUSH_EN, (65,1) 4 idle cycles later.
REQ-026 The bench SHALL apply the same sequence with data_valid held high every cycle; the same records are required, each strobe one cycle wide.
REQ-027 The bench SHALL apply 256 bytes of 0x07, then 0x09; the required emissions are (7,255) on the 256th byte, then (7,1) on 0x09.
REQ-028 The bench SHALL apply 5×0x11, assert rst=0 mid-stream, release it, then send 0x22 0x33; no 0x11 record is allowed, and (0x22,1) is required.
REQ-029 The bench SHALL build without RLE_IDLE_FLUSH_EN, send 0x44 ×3 and idle for 100 cycles; run_valid must remain 0, and a following 0x55 must produce (0x44,3).
REQ-030 With RLE_IDLE_FLUSH_EN, the bench SHALL send 0x66, idle 3 cycles, then send 0x66 again; no flush is allowed, and the later flush must give (0x66,2).
